// File: rtl/riscv_i32m_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies retire MUL_BITS multiplier bits per cycle into a 2*XLEN
// accumulator. Divides use restoring division on operand magnitudes,
// one quotient bit per cycle, followed by a one-cycle sign fix-up.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   muldiv_req__valid     request strobe (taken only while ready)
//   muldiv_req__funct3    RV32M funct3 (0 MUL .. 7 REMU)
//   rs1, rs2              operands, captured on accept
//   cancel                flush; returns to IDLE next cycle
//   result_ack            consumer takes the result in DONE
//   muldiv_req__ready     high in IDLE
//   result_valid          high in DONE
//   result                final result, held while result_valid
//
// state  | meaning
// IDLE   | waiting for a request
// MUL    | shift-add multiply iterations
// DIV    | restoring divide iterations
// FIX    | apply quotient/remainder signs, select result
// DONE   | result held until result_ack
module riscv_i32m_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            muldiv_req__valid,
  input  logic [2:0]      muldiv_req__funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            cancel,
  input  logic            result_ack,
  output logic            muldiv_req__ready,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   MUL_ITERS = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0]   DIV_ITERS = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              msign_q, msign_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] pp;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic              sdiv, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    msign_d  = msign_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    pp       = '0;
    shifted  = {rem_q, quot_q[XLEN-1]};
    diff     = shifted - {1'b0, dvsr_q};
    sdiv     = muldiv_req__funct3[2] & ~muldiv_req__funct3[0];
    a_neg    = sdiv & rs1[XLEN-1];
    b_neg    = sdiv & rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;

    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (muldiv_req__valid) begin
            funct3_d = muldiv_req__funct3;
            if (!muldiv_req__funct3[2]) begin
              state_d  = S_MUL;
              cnt_d    = MUL_ITERS;
              acc_d    = '0;
              mcand_d  = (muldiv_req__funct3 == 3'd1 || muldiv_req__funct3 == 3'd2)
                         ? {{XLEN{rs1[XLEN-1]}}, rs1} : {{XLEN{1'b0}}, rs1};
              mplier_d = rs2;
              msign_d  = (muldiv_req__funct3 == 3'd1) & rs2[XLEN-1];
            end else if (rs2 == '0) begin
              state_d  = S_DONE;
              result_d = muldiv_req__funct3[1] ? rs1 : '1;
            end else if (sdiv && rs1 == MIN_INT && rs2 == '1) begin
              state_d  = S_DONE;
              result_d = muldiv_req__funct3[1] ? '0 : MIN_INT;
            end else begin
              state_d = S_DIV;
              cnt_d   = DIV_ITERS;
              quot_d  = a_mag;
              rem_d   = '0;
              dvsr_d  = b_mag;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
            end
          end
        end
        S_MUL: begin
          for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier_q[i]) pp = pp + (mcand_q << i);
          end
          // A signed multiplier's top digit carries negative weight: the
          // sign-extension bits above it contribute -mcand * 2^MUL_BITS.
          if (cnt_q == CW'(1) && msign_q) pp = pp - (mcand_q << MUL_BITS);
          acc_d    = acc_q + pp;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = S_DONE;
            result_d = (funct3_q == 3'd0) ? acc_d[XLEN-1:0] : acc_d[2*XLEN-1:XLEN];
          end
        end
        S_DIV: begin
          // Dividend bits shift out of quot_q while quotient bits shift in.
          if (shifted >= {1'b0, dvsr_q}) begin
            rem_d  = diff[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d  = shifted[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = funct3_q[1] ? (rneg_q ? -rem_q : rem_q)
                                 : (qneg_q ? -quot_q : quot_q);
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (result_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      msign_q  <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      msign_q  <= msign_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign muldiv_req__ready = (state_q == S_IDLE);
  assign result_valid      = (state_q == S_DONE);
  assign result            = result_q;

endmodule

// File: tb/tb_riscv_i32m_muldiv.sv
// Bench for riscv_i32m_muldiv: four instances (MUL_BITS 4/1/2/8) share
// stimulus; results and latencies are compared against a plain-arithmetic
// reference model.
module tb_riscv_i32m_muldiv;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic        cancel;
  logic        ack;
  logic [3:0]  rdy, rv;
  logic [31:0] res [4];

  int n_chk  = 0;
  int n_fail = 0;

  riscv_i32m_muldiv #(.XLEN(32), .MUL_BITS(4)) u_mb4 (
    .clk(clk), .reset(reset), .muldiv_req__valid(req_valid), .muldiv_req__funct3(f3),
    .rs1(rs1), .rs2(rs2), .cancel(cancel), .result_ack(ack),
    .muldiv_req__ready(rdy[0]), .result_valid(rv[0]), .result(res[0]));
  riscv_i32m_muldiv #(.XLEN(32), .MUL_BITS(1)) u_mb1 (
    .clk(clk), .reset(reset), .muldiv_req__valid(req_valid), .muldiv_req__funct3(f3),
    .rs1(rs1), .rs2(rs2), .cancel(cancel), .result_ack(ack),
    .muldiv_req__ready(rdy[1]), .result_valid(rv[1]), .result(res[1]));
  riscv_i32m_muldiv #(.XLEN(32), .MUL_BITS(2)) u_mb2 (
    .clk(clk), .reset(reset), .muldiv_req__valid(req_valid), .muldiv_req__funct3(f3),
    .rs1(rs1), .rs2(rs2), .cancel(cancel), .result_ack(ack),
    .muldiv_req__ready(rdy[2]), .result_valid(rv[2]), .result(res[2]));
  riscv_i32m_muldiv #(.XLEN(32), .MUL_BITS(8)) u_mb8 (
    .clk(clk), .reset(reset), .muldiv_req__valid(req_valid), .muldiv_req__funct3(f3),
    .rs1(rs1), .rs2(rs2), .cancel(cancel), .result_ack(ack),
    .muldiv_req__ready(rdy[3]), .result_valid(rv[3]), .result(res[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int mb_of(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 2;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int mb);
    if (!op[2]) return 32 / mb + 1;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge; returns at the falling edge of N+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    f3  = op;
    rs1 = a;
    rs2 = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          lat_seen [4];
    logic [31:0] r_seen [4];
    bit          all_seen;
    for (int k = 0; k < 4; k++) begin
      lat_seen[k] = -1;
      r_seen[k]   = '0;
    end
    ack = 1'b1;
    issue(op, a, b);
    for (int lat = 1; lat <= 60; lat++) begin
      all_seen = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (rv[k] && lat_seen[k] < 0) begin
          lat_seen[k] = lat;
          r_seen[k]   = res[k];
        end
        if (lat_seen[k] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("result mb%0d f%0d %h,%h", mb_of(k), op, a, b), 64'(r_seen[k]), 64'(ref_op(op, a, b)));
      chk($sformatf("latency mb%0d f%0d %h,%h", mb_of(k), op, a, b), 64'(lat_seen[k]), 64'(ref_lat(op, a, b, mb_of(k))));
    end
    @(negedge clk);
    ack = 1'b0;
  endtask

  logic [2:0]  d_op [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a  [13] = '{32'h7, 32'h7, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'h1234, 32'hFFFF_FFF9};
  logic [31:0] d_b  [13] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h2, 32'h2, 32'h2,
                             32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

  initial begin
    logic [31:0] held;
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; req_valid = 1'b0; f3 = '0; rs1 = '0; rs2 = '0; cancel = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset ready mb%0d", mb_of(k)), 64'(rdy[k]), 64'd1);
      chk($sformatf("reset valid mb%0d", mb_of(k)), 64'(rv[k]), 64'd0);
      chk($sformatf("reset result mb%0d", mb_of(k)), 64'(res[k]), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_op(d_op[i], d_a[i], d_b[i]);

    // Result held in DONE while ack is low; requests there are ignored.
    ack = 1'b0;
    issue(3'd0, 32'h7, 32'hFFFF_FFFD);
    repeat (7) @(negedge clk);
    chk("hold early valid", 64'(rv[0]), 64'd0);
    @(negedge clk);
    chk("hold valid at N+9", 64'(rv[0]), 64'd1);
    chk("hold result", 64'(res[0]), 64'hFFFF_FFEB);
    held = 32'hFFFF_FFEB;
    req_valid = 1'b1; f3 = 3'd4; rs1 = 32'd100; rs2 = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold valid stable", 64'(rv[0]), 64'd1);
      chk("hold result stable", 64'(res[0]), 64'(held));
      chk("hold ready low", 64'(rdy[0]), 64'd0);
    end
    req_valid = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack ready", 64'(rdy[0]), 64'd1);
    chk("ack valid drop", 64'(rv[0]), 64'd0);
    @(negedge clk);
    chk("no accept in DONE", 64'(rdy[0]), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;

    // Cancel a divide at N+10.
    ack = 1'b1;
    issue(3'd4, 32'hFFFF_FFF9, 32'h2);
    for (int lat = 1; lat < 10; lat++) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel ready", 64'(rdy), 64'hF);
    held = '0;
    for (int i = 0; i < 30; i++) begin
      if (rv != 4'd0) held = 32'd1;
      @(negedge clk);
    end
    chk("cancel no result", 64'(held), 64'd0);
    ack = 1'b0;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset mid-multiply.
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset ready", 64'(rdy[0]), 64'd1);
    chk("midreset valid", 64'(rv[0]), 64'd0);
    chk("midreset result", 64'(res[0]), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        4: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_i32m_muldiv.md
Name: riscv_i32m_muldiv

Overview:
- Iterative multiply/divide unit implementing RV32M (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the combinational integer ALU in the execute stage. Execute issues an operation, stalls until result_valid, then writes back.
- Generalises the single-cycle ALU to multi-cycle, parametrised width and multiply throughput, with a request/result handshake and flush support.

Parameters:
- XLEN, 32, operand/result width; must be a multiple of MUL_BITS.
- MUL_BITS, 4, multiplier bits retired per multiply iteration (1, 2, 4 or 8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- muldiv_req__valid  in  1  operation request.
- muldiv_req__funct3  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  in  XLEN  operand A (dividend/multiplicand).
- rs2  in  XLEN  operand B (divisor/multiplier).
- cancel  in  1  flush; abandons any operation in flight.
- result_ack  in  1  consumer takes the result.
- muldiv_req__ready  out  1  high only in IDLE.
- result_valid  out  1  high only in DONE.
- result  out  XLEN  final result; stable while result_valid.

Behaviour:
- Reset and interface encoding:
  - Reset: state IDLE. result_valid=0, result=0, muldiv_req__ready=1, all internal registers cleared.
  - Reset dominates cancel, and cancel dominates every other input.
  - Decided: one clock, clk. Reset is synchronous and active-high on port reset.
- Accept: a request is taken on a cycle with muldiv_req__valid & muldiv_req__ready & !cancel. Operands and funct3 are captured, so rs1/rs2 may change afterwards.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, on accept:
  - funct3<4 -> MUL, iteration count = XLEN/MUL_BITS.
  - funct3>=4 with rs2==0 -> DONE. Quotient = all ones; remainder = rs1 (signed and unsigned alike).
  - funct3 4/6 with rs1==MIN_INT and rs2==all ones -> DONE. DIV returns MIN_INT; REM returns 0.
  - Otherwise -> DIV, iteration count = XLEN.
- MUL:
  - Operands are extended to 2*XLEN by funct3: signed/signed for MULH, signed/unsigned for MULHSU, unsigned otherwise.
  - Each cycle adds (multiplicand * low MUL_BITS of multiplier) into a 2*XLEN accumulator, shifts the multiplicand left by MUL_BITS and the multiplier right by MUL_BITS. The multiplier is sign-extended for MULH.
  - Arithmetic is modulo 2^(2*XLEN).
  - When the count reaches 0 -> DONE. result = acc[XLEN-1:0] for MUL, else acc[2*XLEN-1:XLEN].
- DIV:
  - Restoring division on magnitudes, 1 bit per cycle, XLEN cycles.
  - For signed ops, operand magnitudes are taken at accept and the signs are recorded.
  - After the last iteration -> FIX.
- FIX (one cycle):
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
  - Result is selected by funct3 -> DONE.
- DONE: result held. On result_ack -> IDLE next cycle, result_valid drops. A new request may be accepted the following cycle, not the same cycle.
- Latency, with accept on cycle N:
  - result_valid first high at N+XLEN/MUL_BITS+1 for multiplies (N+9 at default).
  - N+XLEN+2 for divides (N+34).
  - N+1 for div-by-zero and overflow cases.
- cancel: in any state -> IDLE next cycle. result_valid=0 next cycle; no result is produced. cancel in DONE with result_ack discards the result.
- muldiv_req__valid outside IDLE is ignored. No queuing.
- result_ack outside DONE is ignored.

Test Plan:
- MUL rs1=0x00000007, rs2=0xFFFFFFFD; accept at N -> result_valid at N+9, result=0xFFFFFFEB. Repeat as MULH -> 0xFFFFFFFF, MULHU -> 0x00000006.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result_valid at N+34, result=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIVU rs2=0, rs1=0x1234 -> result_valid at N+1, result=0xFFFFFFFF. REMU -> 0x00001234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1. REM of the same -> 0.
- Hold result_ack low 5 cycles in DONE -> result_valid and result stay stable and muldiv_req__ready=0. Pulse ack -> ready=1 the next cycle. A request during DONE is not accepted.
- Assert cancel at N+10 of a DIV -> IDLE at N+11 and result_valid never asserts. A new MULHU 0xFFFFFFFF*0xFFFFFFFF is accepted immediately -> 0xFFFFFFFE.
- Assert reset mid-MUL -> next cycle state IDLE, result=0, ready=1. Sweep MUL_BITS=1/2/8 with random operands against a reference model; multiply latency must be XLEN/MUL_BITS+1.
